// File: rtl/btn_pkg.sv
// btn_pkg: shared FSM state encoding and default timing constants for the button blocks
package btn_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        GAP    = 3'd2,
        PRESS2 = 3'd3,
        HELD   = 3'd4
    } state_t;
    localparam int unsigned LONG_CYCLES_DEF = 50000;
    localparam int unsigned GAP_CYCLES_DEF  = 20000;
    localparam int unsigned CNT_W_DEF       = 16;
endpackage

// File: rtl/edge_detect.sv
// edge_detect: registered-history rise/fall detector; ports clk, rst, d -> rise, fall
// A level already high when reset releases is not a rise: rise is only armed once a low has been sampled.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic prev_q, prev_d, armed_q, armed_d;
    always_comb begin
        prev_d  = d;
        armed_d = armed_q | ~d;
        rise    = d & ~prev_q & armed_q;
        fall    = ~d & prev_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            armed_q <= armed_d;
        end
    end
endmodule

// File: rtl/button_event_classifier.sv
// button_event_classifier: classifies debounced presses into short/long/double single-cycle pulses
// Ports: clk, rst (async, active-high), clean_in (1 = pressed) -> short_press, long_press, double_press, busy (state != IDLE)
module button_event_classifier
    import btn_pkg::*;
#(
    parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF,
    parameter int unsigned GAP_CYCLES  = GAP_CYCLES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clean_in,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic busy
);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic short_q, short_d, long_q, long_d, double_q, double_d;
    logic rise, fall;
    edge_detect u_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (clean_in),
        .rise (rise),
        .fall (fall)
    );
    // Edges take priority over counter expiry: release on the long threshold stays short, a press on gap expiry is a double.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = rise ? PRESS1 : IDLE;
                cnt_d   = rise ? '0 : cnt_q;
            end
            PRESS1: begin
                long_d  = ~fall & (cnt_q == LONG_LAST);
                state_d = fall ? GAP : long_d ? HELD : PRESS1;
                cnt_d   = fall ? '0 : cnt_q + CNT_W'(1);
            end
            GAP: begin
                short_d = ~rise & (cnt_q == GAP_LAST);
                state_d = rise ? PRESS2 : short_d ? IDLE : GAP;
                cnt_d   = rise ? '0 : cnt_q + CNT_W'(1);
            end
            PRESS2: begin
                double_d = fall;
                state_d  = fall ? IDLE : PRESS2;
            end
            HELD:    state_d = fall ? IDLE : HELD;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            short_q  <= short_d;
            long_q   <= long_d;
            double_q <= double_d;
        end
    end
    assign short_press  = short_q;
    assign long_press   = long_q;
    assign double_press = double_q;
    assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_button_event_classifier.sv
// tb_button_event_classifier: directed and randomized gesture checks against a run-length reference model
module tb_button_event_classifier;
    localparam int LONG = 8;
    localparam int GAP  = 4;
    localparam int MAXN = 256;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clean_in = 1'b0;
    logic short_press, long_press, double_press, busy;
    int checks = 0;
    int failures = 0;
    bit s[MAXN];
    int ev[MAXN];
    bit bz[MAXN];
    int n;
    int n_short, n_long, n_double;
    button_event_classifier #(.LONG_CYCLES(LONG), .GAP_CYCLES(GAP), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .clean_in     (clean_in),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_press (double_press),
        .busy         (busy)
    );
    always #5 clk = ~clk;
    function automatic int outs();
        return int'({short_press, long_press, double_press, busy});
    endfunction
    task automatic chk(input string tag, input int o, input int e);
        checks++;
        if (o != e) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, o, e, $time);
        end
    endtask
    task automatic add(input bit v, input int len);
        for (int k = 0; k < len && n < MAXN; k++) begin
            s[n] = v;
            n++;
        end
    endtask
    function automatic int next_idx(input int from, input bit v);
        for (int k = from; k < n; k++) if (s[k] == v) return k;
        return n;
    endfunction
    task automatic mark(input int idx, input int code);
        if (idx < n) ev[idx] = code;
    endtask
    // Gesture reference: 1=short, 2=long, 3=double, indexed by the sampling edge that decides it.
    task automatic model();
        int t, r, f, r2, f2, e;
        for (int k = 0; k < n; k++) begin
            ev[k] = 0;
            bz[k] = 0;
        end
        t = 1;
        while (t < n) begin
            if (s[t] && !s[t-1]) begin
                r = t;
                f = next_idx(r + 1, 1'b0);
                if (f - r > LONG) begin
                    mark(r + LONG, 2);
                    e = f;
                end else begin
                    r2 = next_idx(f + 1, 1'b1);
                    if (r2 - f <= GAP) begin
                        f2 = next_idx(r2 + 1, 1'b0);
                        mark(f2, 3);
                        e = f2;
                    end else begin
                        mark(f + GAP, 1);
                        e = f + GAP;
                    end
                end
                for (int k = r; k < e && k < n; k++) bz[k] = 1'b1;
                t = e + 1;
            end else begin
                t++;
            end
        end
    endtask
    task automatic do_reset(input bit v);
        rst = 1'b1;
        clean_in = v;
        @(posedge clk);
        #1;
        chk("reset", outs(), 0);
        rst = 1'b0;
    endtask
    task automatic drive(input bit v);
        clean_in = v;
        @(posedge clk);
        #1;
    endtask
    task automatic run_seq(input string tag);
        model();
        n_short = 0;
        n_long = 0;
        n_double = 0;
        do_reset(s[0]);
        for (int i = 0; i < n; i++) begin
            drive(s[i]);
            chk(tag, outs(), int'({ev[i] == 1, ev[i] == 2, ev[i] == 3, bz[i]}));
            n_short += int'(short_press);
            n_long += int'(long_press);
            n_double += int'(double_press);
        end
    endtask
    task automatic counts(input string tag, input int es, input int el, input int ed);
        chk({tag, "_short"}, n_short, es);
        chk({tag, "_long"}, n_long, el);
        chk({tag, "_double"}, n_double, ed);
    endtask
    initial begin
        n = 0; add(0, 2); add(1, 3); add(0, 10);
        run_seq("short"); counts("short", 1, 0, 0);
        n = 0; add(0, 2); add(1, 20); add(0, 6);
        run_seq("long"); counts("long", 0, 1, 0);
        n = 0; add(0, 2); add(1, 2); add(0, 2); add(1, 2); add(0, 8);
        run_seq("double"); counts("double", 0, 0, 1);
        n = 0; add(0, 2); add(1, LONG); add(0, 10);
        run_seq("rel_at_long"); counts("rel_at_long", 1, 0, 0);
        n = 0; add(0, 2); add(1, LONG + 1); add(0, 10);
        run_seq("rel_after_long"); counts("rel_after_long", 0, 1, 0);
        n = 0; add(0, 2); add(1, 2); add(0, GAP); add(1, 2); add(0, 8);
        run_seq("press_at_gap"); counts("press_at_gap", 0, 0, 1);
        n = 0; add(0, 2); add(1, 2); add(0, GAP + 1); add(1, 2); add(0, 8);
        run_seq("press_after_gap"); counts("press_after_gap", 2, 0, 0);
        n = 0; add(1, 5); add(0, 3); add(1, 3); add(0, 10);
        run_seq("held_thru_rst"); counts("held_thru_rst", 1, 0, 0);
        do_reset(1'b0);
        drive(0); drive(0); drive(1); drive(1); drive(0);
        chk("gap_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("rst_in_gap", outs(), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) begin
            drive(0);
            chk("after_rst_gap", outs(), 0);
        end
        do_reset(1'b0);
        drive(0); drive(1); drive(1); drive(1);
        chk("press1_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("rst_in_press1", outs(), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) begin
            drive(1);
            chk("after_rst_press1_hi", outs(), 0);
        end
        repeat (6) begin
            drive(0);
            chk("after_rst_press1_lo", outs(), 0);
        end
        do_reset(1'b0);
        drive(0);
        drive(1);
        repeat (LONG) drive(1);
        chk("long_pulse", int'(long_press), 1);
        rst = 1'b1;
        #1;
        chk("rst_clears_pulse", outs(), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            drive(1);
            chk("after_rst_pulse_hi", outs(), 0);
        end
        repeat (6) begin
            drive(0);
            chk("after_rst_pulse_lo", outs(), 0);
        end
        for (int trial = 0; trial < 40; trial++) begin
            n = 0;
            add(1'($urandom_range(0, 1)), $urandom_range(1, 3));
            while (n < MAXN - 40) begin
                add(1, $urandom_range(1, LONG + 3));
                add(0, $urandom_range(1, GAP + 3));
            end
            add(0, LONG + GAP + 4);
            run_seq("random");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
